// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares a single-ported word data memory between m0 (CPU MEM stage) and m1 (debug/DMA loader)
//  Build macro DMEM_ARB_RR_EN: when defined, round-robin arbitration; otherwise fixed priority with m0 winning.
//  Ports: clk, rst (async, active-high)
//    mN_req/we/size/addr/wdata in, mN_gnt/rdata/err out (N = 0,1)
//    busy out
//    mem_read_en/mem_read_addr out, mem_read_data in
//    mem_write_en/mem_write_addr/mem_write_data out
module dmem_port_arbiter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         m0_req,
    input  logic         m0_we,
    input  logic [1:0]   m0_size,
    input  logic [W-1:0] m0_addr,
    input  logic [W-1:0] m0_wdata,
    output logic         m0_gnt,
    output logic [W-1:0] m0_rdata,
    output logic         m0_err,
    input  logic         m1_req,
    input  logic         m1_we,
    input  logic [1:0]   m1_size,
    input  logic [W-1:0] m1_addr,
    input  logic [W-1:0] m1_wdata,
    output logic         m1_gnt,
    output logic [W-1:0] m1_rdata,
    output logic         m1_err,
    output logic         busy,
    output logic         mem_read_en,
    output logic [W-1:0] mem_read_addr,
    input  logic [W-1:0] mem_read_data,
    output logic         mem_write_en,
    output logic [W-1:0] mem_write_addr,
    output logic [W-1:0] mem_write_data
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, MERGE = 2'd2, DONE = 2'd3;
    logic [1:0]   state_q, state_d, size_q, size_d;
    logic         port_q, port_d, we_q, we_d, err_q, err_d;
    logic [W-1:0] addr_q, addr_d, wdata_q, wdata_d, merged_q, merged_d;
    logic [W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic         pref, win, any_req, bad;
    logic [4:0]   sh;
    logic [W-1:0] mask, lane;
`ifdef DMEM_ARB_RR_EN
    logic ptr_q, ptr_d;
    assign pref = ptr_q;
    // the port just granted becomes the non-preferred one
    always_comb ptr_d = (state_q == IDLE && any_req) ? ~win : ptr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 1'b0;
        else ptr_q <= ptr_d;
    end
`else
    assign pref = 1'b0;
`endif
    always_comb begin
        any_req  = m0_req | m1_req;
        win      = (m0_req & m1_req) ? pref : m1_req;
        sh       = {addr_q[1:0], 3'b000};
        mask     = size_q == 2'b00 ? W'(8'hFF) : size_q == 2'b01 ? W'(16'hFFFF) : '1;
        bad      = size_q == 2'b11 || (size_q == 2'b01 && addr_q[0]) || (size_q == 2'b10 && addr_q[1:0] != 2'b00);
        lane     = (mem_read_data >> sh) & mask;
        state_d  = state_q;
        port_d   = port_q;
        we_d     = we_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        merged_d = merged_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (state_q == IDLE && any_req) begin
            state_d = ACCESS;
            port_d  = win;
            we_d    = win ? m1_we : m0_we;
            size_d  = win ? m1_size : m0_size;
            addr_d  = win ? m1_addr : m0_addr;
            wdata_d = win ? m1_wdata : m0_wdata;
        end else if (state_q == ACCESS) begin
            err_d    = bad;
            state_d  = (!bad && we_q && size_q != 2'b10) ? MERGE : DONE;
            merged_d = (mem_read_data & ~(mask << sh)) | ((wdata_q & mask) << sh);
            if (!bad && !we_q && !port_q) rdata0_d = lane;
            if (!bad && !we_q && port_q) rdata1_d = lane;
        end else if (state_q == MERGE) begin
            state_d = DONE;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            port_q   <= 1'b0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            merged_q <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            we_q     <= we_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            merged_q <= merged_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end
    // memory strobes decode from registered state so an async reset kills a write at once
    assign busy           = state_q != IDLE;
    assign mem_read_en    = state_q == ACCESS;
    assign mem_read_addr  = {addr_q[W-1:2], 2'b00};
    assign mem_write_en   = (state_q == ACCESS && we_q && size_q == 2'b10 && !bad) || state_q == MERGE;
    assign mem_write_addr = {addr_q[W-1:2], 2'b00};
    assign mem_write_data = state_q == MERGE ? merged_q : mem_write_en ? wdata_q : '0;
    assign m0_gnt         = state_q == DONE && !port_q;
    assign m1_gnt         = state_q == DONE && port_q;
    assign m0_err         = m0_gnt && err_q;
    assign m1_err         = m1_gnt && err_q;
    assign m0_rdata       = rdata0_q;
    assign m1_rdata       = rdata1_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: randomized self-checking bench for dmem_port_arbiter with a byte-level memory model
module tb_dmem_port_arbiter;
    logic        clk = 1'b0, rst = 1'b1, mem_init = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [1:0]  m0_size = 2'b00, m1_size = 2'b00;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic        m0_gnt, m0_err, m1_gnt, m1_err, busy, mem_read_en, mem_write_en;
    logic [31:0] m0_rdata, m1_rdata, mem_read_addr, mem_read_data, mem_write_addr, mem_write_data;
    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic [31:0] last_rd [0:1];
    logic [31:0] last_raddr = '0, last_waddr = '0;
    int          rd_cnt = 0, wr_cnt = 0, pass_cnt = 0, total = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .busy(busy),
        .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
        .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data)
    );

    assign mem_read_data = mem[mem_read_addr[7:2]];

    always @(posedge clk) begin
        if (mem_init) for (int i = 0; i < 64; i++) mem[i] <= 32'h0F00_0000 + i * 32'h0001_0203;
        else if (mem_write_en) mem[mem_write_addr[7:2]] <= mem_write_data;
        if (mem_read_en) begin
            rd_cnt <= rd_cnt + 1;
            last_raddr <= mem_read_addr;
        end
        if (mem_write_en) begin
            wr_cnt <= wr_cnt + 1;
            last_waddr <= mem_write_addr;
        end
    end

    task automatic drive(input int p, input logic req, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            m0_req = req; m0_we = we; m0_size = size; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_size = size; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    // one complete transaction on port p, checked against the byte-level model
    task automatic do_op(input int p, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int nb, a, idx, cyc, rd0, wr0, exp_lat, exp_wr;
        logic bad;
        logic [31:0] word, exp_rd, got_rd, aligned;
        logic got_err, oth_gnt, oth_err;
        nb = size == 2'b00 ? 1 : size == 2'b01 ? 2 : 4;
        a = int'(addr[1:0]);
        idx = int'(addr[7:2]);
        aligned = {addr[31:2], 2'b00};
        bad = size == 2'b11 || (a % nb) != 0;
        word = ref_mem[idx];
        exp_rd = last_rd[p];
        if (!bad && !we) begin
            exp_rd = '0;
            for (int k = 0; k < nb; k++) exp_rd[8*k +: 8] = word[8*(a+k) +: 8];
        end
        exp_lat = (!bad && we && nb < 4) ? 3 : 2;
        exp_wr = (!bad && we) ? 1 : 0;
        @(negedge clk);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        drive(p, 1'b1, we, size, addr, wdata);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(p == 1 ? m1_gnt : m0_gnt) && cyc < 10);
        got_rd  = p == 1 ? m1_rdata : m0_rdata;
        got_err = p == 1 ? m1_err : m0_err;
        oth_gnt = p == 1 ? m0_gnt : m1_gnt;
        oth_err = p == 1 ? m0_err : m1_err;
        drive(p, 1'b0, we, size, addr, wdata);
        if (!bad && we) for (int k = 0; k < nb; k++) word[8*(a+k) +: 8] = wdata[8*k +: 8];
        ref_mem[idx] = word;
        last_rd[p] = exp_rd;
        total++;
        if (cyc !== exp_lat) $display("FAIL latency p%0d addr=%h size=%0d we=%0d: got %0d exp %0d", p, addr, size, we, cyc, exp_lat);
        else pass_cnt++;
        total++;
        if (got_err !== bad) $display("FAIL err p%0d addr=%h size=%0d: got %0d exp %0d", p, addr, size, got_err, bad);
        else pass_cnt++;
        total++;
        if (got_rd !== exp_rd) $display("FAIL rdata p%0d addr=%h size=%0d we=%0d: got %h exp %h", p, addr, size, we, got_rd, exp_rd);
        else pass_cnt++;
        total++;
        if ({oth_gnt, oth_err, busy} !== 3'b001) $display("FAIL other_port/busy p%0d: got %b exp 001", p, {oth_gnt, oth_err, busy});
        else pass_cnt++;
        total++;
        if (rd_cnt - rd0 !== 1 || last_raddr !== aligned) $display("FAIL mem_read p%0d: got %0d reads at %h exp 1 at %h", p, rd_cnt - rd0, last_raddr, aligned);
        else pass_cnt++;
        total++;
        if (wr_cnt - wr0 !== exp_wr) $display("FAIL mem_write_count p%0d addr=%h size=%0d: got %0d exp %0d", p, addr, size, wr_cnt - wr0, exp_wr);
        else pass_cnt++;
        if (exp_wr == 1) begin
            total++;
            if (last_waddr !== aligned) $display("FAIL mem_write_addr p%0d: got %h exp %h", p, last_waddr, aligned);
            else pass_cnt++;
        end
        total++;
        if (mem[idx] !== ref_mem[idx]) $display("FAIL mem_word %h: got %h exp %h", aligned, mem[idx], ref_mem[idx]);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({m0_gnt, m0_err, m1_gnt, m1_err, busy, mem_read_en, mem_write_en} !== 7'b0)
            $display("FAIL reset_ctrl: got %b exp 0000000", {m0_gnt, m0_err, m1_gnt, m1_err, busy, mem_read_en, mem_write_en});
        else pass_cnt++;
        total++;
        if ({m0_rdata, m1_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h exp 0", {m0_rdata, m1_rdata});
        else pass_cnt++;
        total++;
        if ({mem_read_addr, mem_write_addr, mem_write_data} !== 96'h0)
            $display("FAIL reset_mem_bus: got %h exp 0", {mem_read_addr, mem_write_addr, mem_write_data});
        else pass_cnt++;
        mem_init = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, m0_gnt, m1_gnt} !== 3'b000) $display("FAIL idle_after_reset: got %b exp 000", {busy, m0_gnt, m1_gnt});
        else pass_cnt++;
    endtask

    task automatic test_word;
        do_op(0, 1'b1, 2'b10, 32'h1001_0004, 32'hDEAD_BEEF);
        do_op(0, 1'b0, 2'b10, 32'h1001_0004, 32'h0);
        total++;
        if (m0_rdata !== 32'hDEAD_BEEF) $display("FAIL word_load: got %h exp deadbeef", m0_rdata);
        else pass_cnt++;
    endtask

    task automatic test_subword_store;
        do_op(1, 1'b1, 2'b00, 32'h1001_0005, 32'h0000_00AA);
        total++;
        if (mem[1] !== 32'hDEAD_AAEF) $display("FAIL byte_store_merge: got %h exp deadaaef", mem[1]);
        else pass_cnt++;
    endtask

    task automatic test_subword_load;
        do_op(0, 1'b0, 2'b01, 32'h1001_0006, 32'h0);
        total++;
        if (m0_rdata !== 32'h0000_DEAD) $display("FAIL half_load: got %h exp 0000dead", m0_rdata);
        else pass_cnt++;
        do_op(0, 1'b0, 2'b00, 32'h1001_0004, 32'h0);
        total++;
        if (m0_rdata !== 32'h0000_00EF) $display("FAIL byte_load: got %h exp 000000ef", m0_rdata);
        else pass_cnt++;
    endtask

    task automatic test_misaligned;
        do_op(0, 1'b0, 2'b01, 32'h1001_0003, 32'h0);
        do_op(1, 1'b1, 2'b10, 32'h1001_0002, 32'h1234_5678);
        do_op(0, 1'b1, 2'b11, 32'h1001_0008, 32'h1234_5678);
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  32'h1001_0000 | 32'($urandom_range(0, 255)), $urandom);
        end
    endtask

    task automatic test_priority;
        int n = 0, n0 = 0, n1 = 0, cyc = 0, exp_p, got_p;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        drive(0, 1'b1, 1'b0, 2'b10, 32'h1001_0020, 32'h0);
        drive(1, 1'b1, 1'b0, 2'b10, 32'h1001_0040, 32'h0);
        while (n < 8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (m0_gnt || m1_gnt) begin
`ifdef DMEM_ARB_RR_EN
                exp_p = n % 2;
`else
                exp_p = n < 4 ? 0 : 1;
`endif
                got_p = m1_gnt ? 1 : 0;
                total++;
                if (got_p !== exp_p) $display("FAIL grant_order #%0d: got m%0d exp m%0d", n, got_p, exp_p);
                else pass_cnt++;
                if (m0_gnt) begin
                    total++;
                    if (m0_rdata !== ref_mem[8+n0]) $display("FAIL prio_rdata m0 #%0d: got %h exp %h", n0, m0_rdata, ref_mem[8+n0]);
                    else pass_cnt++;
                    last_rd[0] = ref_mem[8+n0];
                    n0++;
                    if (n0 < 4) m0_addr = 32'h1001_0020 + 32'(4 * n0);
                    else m0_req = 1'b0;
                end else begin
                    total++;
                    if (m1_rdata !== ref_mem[16+n1]) $display("FAIL prio_rdata m1 #%0d: got %h exp %h", n1, m1_rdata, ref_mem[16+n1]);
                    else pass_cnt++;
                    last_rd[1] = ref_mem[16+n1];
                    n1++;
                    if (n1 < 4) m1_addr = 32'h1001_0040 + 32'(4 * n1);
                    else m1_req = 1'b0;
                end
                n++;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        total++;
        if (n !== 8) $display("FAIL grant_count: got %0d exp 8", n);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_merge;
        int g = 0;
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 2'b00, 32'h1001_0009, 32'h0000_0055);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (mem_write_en !== 1'b1) $display("FAIL merge_write_en: got %b exp 1", mem_write_en);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total++;
        if ({mem_write_en, busy, m0_gnt, m1_gnt} !== 4'b0) $display("FAIL async_reset_outputs: got %b exp 0000", {mem_write_en, busy, m0_gnt, m1_gnt});
        else pass_cnt++;
        drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (m0_gnt || m1_gnt || busy) g++;
        end
        total++;
        if (g !== 0) $display("FAIL aborted_op_activity: got %0d cycles exp 0", g);
        else pass_cnt++;
        total++;
        if (mem[2] !== ref_mem[2]) $display("FAIL aborted_merge_word: got %h exp %h", mem[2], ref_mem[2]);
        else pass_cnt++;
        total++;
        if (m1_rdata !== 32'h0) $display("FAIL rdata_after_reset: got %h exp 0", m1_rdata);
        else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0F00_0000 + i * 32'h0001_0203;
        last_rd[0] = '0;
        last_rd[1] = '0;
        test_reset;
        test_word;
        test_subword_store;
        test_subword_load;
        test_misaligned;
        test_random;
        test_priority;
        test_reset_in_merge;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
